// File: rtl/fir_stream_pkg.sv
// Shared definitions for the FIR streaming path: default sample width and
// handshake helpers used by the deserializer, filter, FIFO and serializer.
package fir_stream_pkg;

    localparam int unsigned FirDataWidth = 24;

    // Address bits needed to index a memory of the given depth (at least 1).
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic logic fire(input logic valid, input logic ready, input logic en);
        return valid & ready & en;
    endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// Simple dual-port RAM: registered synchronous write, asynchronous read, no reset.
module fifo_ram_sdp #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_W     = 3
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     iv_waddr,
    input  logic [DATA_WIDTH-1:0] iv_wdata,
    input  logic [ADDR_W-1:0]     iv_raddr,
    output logic [DATA_WIDTH-1:0] ov_rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[iv_waddr] <= iv_wdata;
        end
    end

    assign ov_rdata = mem[iv_raddr];

endmodule

// File: rtl/fir_output_fifo.sv
// First-word-fall-through elastic buffer between the FIR filter and the serializer.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fir_output_fifo
    import fir_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = FirDataWidth,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned AFULL_LEVEL = 6
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_en,
    input  logic [DATA_WIDTH-1:0]      iv_din,
    input  logic                       i_din_valid,
    output logic                       o_ready,
    output logic [DATA_WIDTH-1:0]      ov_dout,
    output logic                       o_dout_valid,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH):0]     ov_count,
    output logic                       o_almost_full
);

    localparam int unsigned AddrW = addr_width(DEPTH);

    logic [AddrW:0]        wr_ptr_q, wr_ptr_d;
    logic [AddrW:0]        rd_ptr_q, rd_ptr_d;
    logic                  empty, full;
    logic                  push, pop;
    logic [DATA_WIDTH-1:0] rd_data;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

    assign o_ready      = ~full & ~i_rst;
    assign o_dout_valid = ~empty;

    assign push = fire(i_din_valid, o_ready, i_en);
    assign pop  = fire(o_dout_valid, i_ready, i_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    fifo_ram_sdp #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (AddrW)
    ) u_ram (
        .i_clk    (i_clk),
        .i_we     (push),
        .iv_waddr (wr_ptr_q[AddrW-1:0]),
        .iv_wdata (iv_din),
        .iv_raddr (rd_ptr_q[AddrW-1:0]),
        .ov_rdata (rd_data)
    );

    // Never expose stale RAM contents while empty.
    assign ov_dout       = empty ? '0 : rd_data;
    assign ov_count      = wr_ptr_q - rd_ptr_q;
    assign o_almost_full = (ov_count >= ($clog2(DEPTH) + 1)'(AFULL_LEVEL));

    a_no_overflow : assert property (@(posedge i_clk) disable iff (i_rst) !(push && full));
    a_no_underflow : assert property (@(posedge i_clk) disable iff (i_rst) !(pop && empty));

endmodule

// File: tb/tb_fir_output_fifo.sv
// Self-checking bench for fir_output_fifo: queue-based reference model checked every
// cycle, plus directed literal expectations.
module tb_fir_output_fifo;

    localparam int unsigned Dw    = 24;
    localparam int unsigned Depth = 8;
    localparam int unsigned Afull = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [Dw-1:0] din;
    logic          din_valid;
    logic          out_ready;
    logic [Dw-1:0] dout;
    logic          dout_valid;
    logic          ready;
    logic [3:0]    count;
    logic          afull;

    int n_checks = 0;
    int n_errors = 0;

    logic [Dw-1:0] model_q[$];
    bit            chk_on = 1'b0;

    always #5 clk = ~clk;

    fir_output_fifo #(
        .DATA_WIDTH  (Dw),
        .DEPTH       (Depth),
        .AFULL_LEVEL (Afull)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_en          (en),
        .iv_din        (din),
        .i_din_valid   (din_valid),
        .o_ready       (out_ready),
        .ov_dout       (dout),
        .o_dout_valid  (dout_valid),
        .i_ready       (ready),
        .ov_count      (count),
        .o_almost_full (afull)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a bounded queue updated from the inputs seen at each edge.
    always @(posedge clk) begin
        if (rst) begin
            model_q.delete();
            chk_on <= 1'b1;
        end else if (en) begin
            bit do_push;
            bit do_pop;
            do_push = din_valid && (model_q.size() < Depth);
            do_pop  = ready && (model_q.size() > 0);
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(din);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            int unsigned sz;
            sz = model_q.size();
            check("m_ready", {31'b0, out_ready}, {31'b0, (sz < Depth) && !rst});
            check("m_valid", {31'b0, dout_valid}, {31'b0, sz > 0});
            check("m_dout", {8'b0, dout}, (sz > 0) ? {8'b0, model_q[0]} : 32'h0);
            check("m_count", {28'b0, count}, sz);
            check("m_afull", {31'b0, afull}, {31'b0, sz >= Afull});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; din = '0; din_valid = 1'b0; ready = 1'b0;
        step();
        step();
        check("rst_ready", {31'b0, out_ready}, 32'h0);
        check("rst_dout", {8'b0, dout}, 32'h0);
        rst = 1'b0;
        #1;
        check("idle_ready", {31'b0, out_ready}, 32'h1);
        check("idle_valid", {31'b0, dout_valid}, 32'h0);
        check("idle_count", {28'b0, count}, 32'h0);

        // Fill with the serializer stalled.
        for (int i = 1; i <= 8; i++) begin
            din = Dw'(i); din_valid = 1'b1;
            step();
            check("fill_count", {28'b0, count}, i);
            check("fill_afull", {31'b0, afull}, {31'b0, i >= 6});
        end
        check("full_ready", {31'b0, out_ready}, 32'h0);
        din = 24'hABCDEF;
        step();
        check("ovf_count", {28'b0, count}, 32'd8);
        check("ovf_head", {8'b0, dout}, 32'h1);
        din_valid = 1'b0;

        // Drain.
        ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("drain_dout", {8'b0, dout}, i);
            step();
        end
        check("drain_valid", {31'b0, dout_valid}, 32'h0);
        check("drain_dout0", {8'b0, dout}, 32'h0);
        ready = 1'b0;

        // Prime to 4 entries, then stream push+pop for 20 cycles.
        for (int i = 0; i < 4; i++) begin
            din = Dw'(32'h100 + i); din_valid = 1'b1;
            step();
        end
        ready = 1'b1;
        for (int i = 4; i < 24; i++) begin
            din = Dw'(32'h100 + i);
            step();
            check("stream_count", {28'b0, count}, 32'd4);
        end
        check("stream_head", {8'b0, dout}, 32'h114);
        din_valid = 1'b0;
        step();
        ready = 1'b0;
        check("pre_en_count", {28'b0, count}, 32'd3);

        // Enable low: nothing moves even with both handshakes high.
        en = 1'b0; din_valid = 1'b1; ready = 1'b1; din = 24'h00DEAD;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_count", {28'b0, count}, 32'd3);
            check("hold_dout", {8'b0, dout}, 32'h115);
        end
        en = 1'b1; din_valid = 1'b0; ready = 1'b0;

        // Build to 5 entries, then reset with traffic active.
        for (int i = 0; i < 2; i++) begin
            din = Dw'(32'h200 + i); din_valid = 1'b1;
            step();
        end
        check("pre_rst_count", {28'b0, count}, 32'd5);
        din = 24'h000300; ready = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; din_valid = 1'b0; ready = 1'b0;
        #1;
        check("post_rst_count", {28'b0, count}, 32'h0);
        check("post_rst_valid", {31'b0, dout_valid}, 32'h0);
        din = 24'h123456; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        check("after_rst_dout", {8'b0, dout}, 32'h123456);
        check("after_rst_count", {28'b0, count}, 32'h1);
        ready = 1'b1;
        step();
        check("final_valid", {31'b0, dout_valid}, 32'h0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fir_output_fifo.md
# fir_output_fifo

Synchronous first-word-fall-through elastic buffer that sits between `fir_filter_transposed_pipelined` and `serializer_fsm`. It absorbs filter output samples while the serializer is busy shifting a previous word, so the filter stalls only when the buffer is full. Both sides use the team's valid/ready handshake and obey the shared `i_en` qualifier.

## Interface
- `DATA_WIDTH`, 24, sample width in bits.
- `DEPTH`, 8, number of entries; power of two, at least 2.
- `AFULL_LEVEL`, 6, occupancy at or above which `o_almost_full` asserts; range 1..DEPTH.
- `i_clk`  in  1  single clock; all logic on the rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_en`  in  1  global enable; when low, no push, no pop, and state holds.
- `iv_din`  in  DATA_WIDTH  sample from the FIR filter.
- `i_din_valid`  in  1  upstream sample valid.
- `o_ready`  out  1  space available, toward the FIR `i_ready`.
- `ov_dout`  out  DATA_WIDTH  head-of-queue sample, toward the serializer.
- `o_dout_valid`  out  1  queue non-empty.
- `i_ready`  in  1  serializer can accept.
- `ov_count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `o_almost_full`  out  1  `ov_count >= AFULL_LEVEL`.

## Operation
- Push = `i_en & i_din_valid & o_ready`. The write goes to `mem[wr_ptr]`, and `wr_ptr` increments.
- Pop = `i_en & o_dout_valid & i_ready`. `rd_ptr` increments.
- Pointers are $clog2(DEPTH)+1 bits wide and wrap naturally.
  - Empty when the pointers are equal.
  - Full when the MSBs differ and the remaining bits are equal.
- `ov_count = wr_ptr - rd_ptr`, taken modulo 2^(ADDR_W+1).
- `o_ready = ~full & ~i_rst`. `o_dout_valid = ~empty`.
- `ov_dout = mem[rd_ptr]` when non-empty, and forced to 0 when empty. It must not show stale RAM contents.
- Both handshakes are independent: `o_ready` does not depend on `i_ready`, and `o_dout_valid` does not depend on `i_din_valid`. There are no combinational paths between the two sides.
- No write-through: a sample pushed into an empty FIFO is not visible on `ov_dout` in the same cycle.
- Simultaneous push and pop with 0 < count < DEPTH: both occur and the count is unchanged.
- Full: `o_ready` = 0, so a push is impossible even if a pop occurs in the same cycle. Space becomes visible the cycle after the pop.
- Empty: `o_dout_valid` = 0, so a pop is impossible. A push makes the FIFO non-empty the next cycle.
- `i_en` low: pointers, count and memory hold. Outputs still reflect the held state, but no transfer is counted even if valid and ready are both high.
- Overflow and underflow are structurally impossible. Assertions check that push never occurs while full and pop never occurs while empty.

## Timing
- Reset, synchronous, takes effect at the next edge:
  - `wr_ptr` = `rd_ptr` = 0.
  - `ov_count` = 0, `o_dout_valid` = 0, `ov_dout` = 0, `o_almost_full` = 0.
  - `o_ready` is 0 while `i_rst` is high and 1 on the first cycle after release.
- Memory contents are not reset.
- Reset asserted mid-operation discards all entries at that edge. A handshake in the reset cycle is not counted.
- Latency: a push at edge N gives `o_dout_valid` = 1 and the sample on `ov_dout` after edge N, i.e. one cycle, for an empty FIFO.
- Throughput: one push and one pop per cycle, sustained.
- `ov_count` and `o_almost_full` update at the same edge as the pointers.

## Structure
- The shared package `fir_stream_pkg` holds:
  - the default `DATA_WIDTH`;
  - the `clog2`-based address-width helper;
  - the handshake-fire helper function (`valid & ready & en`), also used by the deserializer, filter and serializer.
- One sub-module, `fifo_ram_sdp`: a simple dual-port RAM with a registered synchronous write, an asynchronous read and no reset, sized DEPTH x DATA_WIDTH.
- Pointer, flag and count logic lives in `fir_output_fifo`.
- `top_level` is updated to insert this block between `fir_filter_inst` and `serializer_inst`.

## Test plan
- Reset then idle:
  - during reset, `o_ready` = 0 and `ov_dout` = 0;
  - after release, `o_ready` = 1, `o_dout_valid` = 0, `ov_count` = 0.
- Fill with `i_ready` = 0, pushing 0x000001..0x000008:
  - `ov_count` steps 1..8 and `o_almost_full` rises at count 6;
  - `o_ready` = 0 at count 8, and a 9th valid 0xABCDEF is not accepted.
- Drain the full FIFO with `i_ready` = 1:
  - `ov_dout` = 0x000001..0x000008 on consecutive cycles;
  - `o_dout_valid` falls after the 8th pop and `ov_dout` returns to 0.
- Simultaneous push and pop at count 4 for 20 cycles:
  - count stays at 4 and output order matches input order;
  - pointers wrap without error.
- `i_en` low for 5 cycles with valid and ready held high at count 3: count, `ov_dout` and order are unchanged.
- Reset asserted at count 5 with traffic active: next cycle count = 0 and `o_dout_valid` = 0, and a following push of 0x123456 emerges first.
